// File: rtl/uart_tx_buf_if.sv
// Write-side bundle of the buffered UART transmitter: byte push path plus FIFO status.
// The master drives bytes in; the slave (uart_tx_buf) reports occupancy and overflow.
interface uart_tx_buf_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic          busy;
   logic          ovf;
   logic [CW-1:0] count;

   modport master (output wr_en, wr_data, input full, busy, count, ovf);
   modport slave  (input wr_en, wr_data, output full, busy, count, ovf);
endinterface

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: DEPTH-entry byte FIFO feeding an 8N1 serializer on txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_buf #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200,
   parameter int DEPTH    = 16
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_buf_if.slave   bus,
   output logic           txd
);
   localparam int DIV = CLK_FREQ / BAUD;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int BW  = $clog2(DIV);
   localparam logic [BW-1:0] LAST = BW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   state_t        state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    sh;
`ifdef UART_TX_PARITY_EN
   logic          par;
`endif
   logic          push;
   logic          pop;
   logic          tick;

   assign bus.full  = (count == CW'(DEPTH));
   assign bus.ovf   = bus.wr_en && bus.full;
   assign bus.busy  = (state != IDLE) || (count != '0);
   assign bus.count = count;

   // A same-cycle pop never frees room for a push while full: push looks only at registered count.
   assign push = bus.wr_en && !bus.full;
   assign tick = (baud_cnt == LAST);
   assign pop  = (count != '0) && ((state == IDLE) || ((state == STOP) && tick));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         sh       <= '0;
         txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         if (state != IDLE) baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
         if (pop) begin
            sh       <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par      <= ^mem[rd_ptr];
`endif
            baud_cnt <= '0;
            bit_idx  <= '0;
         end
         case (state)
            IDLE: begin
               txd <= 1'b1;
               if (pop) state <= START;
            end
            START: begin
               txd <= 1'b0;
               if (tick) state <= DATA;
            end
            DATA: begin
               txd <= sh[0];
               if (tick) begin
                  sh      <= sh >> 1;
                  bit_idx <= bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
                  if (bit_idx == 3'd7) state <= PARITY;
`else
                  if (bit_idx == 3'd7) state <= STOP;
`endif
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               txd <= par;
               if (tick) state <= STOP;
            end
`endif
            STOP: begin
               txd <= 1'b1;
               if (tick) state <= pop ? START : IDLE;
            end
            default: begin
               txd   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf at DIV=10: table-driven single frames plus back-to-back,
// overflow, pointer-wrap and mid-frame reset sequences; a line monitor decodes every frame.
module tb_uart_tx_buf;
   localparam int CLK_FREQ = 1000;
   localparam int BAUD     = 100;
   localparam int DIV      = 10;
   localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB       = 11;
`else
   localparam int NB       = 10;
`endif

   typedef struct {
      logic [7:0]  data;
      logic [10:0] bits;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic txd;

   uart_tx_buf_if #(.DEPTH(DEPTH)) bus ();

   uart_tx_buf #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD),
      .DEPTH   (DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .txd(txd)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  rx_q [$];
   vec_t        vecs [7];

   logic        mon_in  = 1'b0;
   int          mon_cyc = 0;
   logic [10:0] mon_fr  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (bus.busy && n < budget) begin
         tick();
         n++;
      end
      check({name, "_idle_timeout"}, bus.busy, 0);
      repeat (3) tick();
   endtask

   task automatic check_rx(input string name, input logic [7:0] exp);
      check({name, "_avail"}, rx_q.size() != 0, 1);
      if (rx_q.size() != 0) check(name, rx_q.pop_front(), exp);
   endtask

   // Entered just after the edge two cycles past the push; c counts cycles after that push edge.
   task automatic expect_frame(input string tag, input logic [10:0] bits, input bit solo);
      logic [DIV-1:0] s;
      int c;
      for (int b = 0; b < NB; b++) begin
         for (int j = 0; j < DIV; j++) begin
            s[j] = txd;
            c = 2 + b * DIV + j;
            if (solo && c == NB * DIV)     check({tag, "_busy_last"}, bus.busy, 1);
            if (solo && c == NB * DIV + 1) check({tag, "_busy_fall"}, bus.busy, 0);
            tick();
         end
         check($sformatf("%s_bit%0d", tag, b), s, {DIV{bits[b]}});
      end
   endtask

   // Line monitor: decodes frames by sampling the middle of each bit period.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            mon_in = 1'b0;
         end else if (!mon_in) begin
            if (txd === 1'b0) begin
               mon_in  = 1'b1;
               mon_cyc = 0;
            end
         end else begin
            mon_cyc++;
         end
         if (mon_in && rst) begin
            if (mon_cyc % DIV == DIV / 2) mon_fr[mon_cyc / DIV] = txd;
            if (mon_cyc == NB * DIV - 1) begin
               mon_in = 1'b0;
               check("mon_start", mon_fr[0], 0);
               check("mon_stop", mon_fr[NB-1], 1);
`ifdef UART_TX_PARITY_EN
               check("mon_parity", mon_fr[9], ^mon_fr[8:1]);
`endif
               rx_q.push_back(mon_fr[8:1]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef UART_TX_PARITY_EN
      vecs[0] = '{8'h55, 11'h4AA};
      vecs[1] = '{8'h00, 11'h400};
      vecs[2] = '{8'hFF, 11'h5FE};
      vecs[3] = '{8'h80, 11'h700};
      vecs[4] = '{8'h01, 11'h602};
      vecs[5] = '{8'hA3, 11'h546};
      vecs[6] = '{8'h07, 11'h60E};
`else
      vecs[0] = '{8'h55, 11'h2AA};
      vecs[1] = '{8'h00, 11'h200};
      vecs[2] = '{8'hFF, 11'h3FE};
      vecs[3] = '{8'h80, 11'h300};
      vecs[4] = '{8'h01, 11'h202};
      vecs[5] = '{8'hA3, 11'h346};
      vecs[6] = '{8'h07, 11'h20E};
`endif

      rst         = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      tick();
      tick();
      check("rst_txd", txd, 1);
      check("rst_count", bus.count, 0);
      check("rst_full", bus.full, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ovf", bus.ovf, 0);
      rst = 1'b1;
      repeat (3) tick();

      // Isolated frames: latency, bit timing, count and busy behaviour.
      for (int v = 0; v < 7; v++) begin
         string tag;
         tag = $sformatf("tbl%0d", v);
         rx_q.delete();
         push(vecs[v].data);
         check({tag, "_count_push"}, bus.count, 1);
         check({tag, "_txd_c0"}, txd, 1);
         tick();
         check({tag, "_count_pop"}, bus.count, 0);
         check({tag, "_txd_c1"}, txd, 1);
         tick();
         expect_frame(tag, vecs[v].bits, 1'b1);
         check({tag, "_txd_after"}, txd, 1);
         check_rx({tag, "_rx"}, vecs[v].data);
         repeat (5) tick();
      end

      // Back-to-back frames with no idle gap.
      push(8'hA3);
      push(8'h0F);
      check("b2b_count", bus.count, 1);
      tick();
`ifdef UART_TX_PARITY_EN
      expect_frame("b2b_a3", 11'h546, 1'b0);
      expect_frame("b2b_0f", 11'h41E, 1'b0);
`else
      expect_frame("b2b_a3", 11'h346, 1'b0);
      expect_frame("b2b_0f", 11'h21E, 1'b0);
`endif
      wait_idle("b2b", 4 * NB * DIV);

      // Overflow: 18 pushes while the first frame starts; 0x11 must be dropped.
      rx_q.delete();
      for (int i = 0; i < DEPTH + 2; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = 8'(i);
         check($sformatf("ovf_pulse%0d", i), bus.ovf, (i == DEPTH + 1));
         tick();
         check($sformatf("ovf_full%0d", i), bus.full, (i >= DEPTH));
         check($sformatf("ovf_count%0d", i), bus.count,
               (i == 0) ? 1 : ((i > DEPTH) ? DEPTH : i));
      end
      bus.wr_en = 1'b0;
      #1;
      check("ovf_idle_pulse", bus.ovf, 0);
      wait_idle("ovf", (DEPTH + 4) * NB * DIV);
      check("ovf_rx_len", rx_q.size(), DEPTH + 1);
      for (int k = 0; k <= DEPTH; k++) check_rx($sformatf("ovf_rx%0d", k), 8'(k));

      // Three fill/drain rounds with the pointers starting mid-buffer.
      for (int r = 0; r < 3; r++) begin
         rx_q.delete();
         for (int i = 0; i < DEPTH; i++) begin
            push(8'(r * 16 + i) ^ 8'h5A);
            check($sformatf("wrap%0d_full%0d", r, i), bus.full, 0);
         end
         check($sformatf("wrap%0d_count_peak", r), bus.count, DEPTH - 1);
         wait_idle($sformatf("wrap%0d", r), (DEPTH + 4) * NB * DIV);
         check($sformatf("wrap%0d_count_end", r), bus.count, 0);
         check($sformatf("wrap%0d_rx_len", r), rx_q.size(), DEPTH);
         for (int i = 0; i < DEPTH; i++)
            check_rx($sformatf("wrap%0d_rx%0d", r, i), 8'(r * 16 + i) ^ 8'h5A);
      end

      // Mid-frame reset with a second byte still queued.
      rx_q.delete();
      push(8'hFF);
      push(8'h3C);
      tick();
      repeat (40) tick();
      check("mrst_busy_before", bus.busy, 1);
      check("mrst_count_before", bus.count, 1);
      rst = 1'b0;
      #1;
      check("mrst_txd", txd, 1);
      check("mrst_count", bus.count, 0);
      check("mrst_busy", bus.busy, 0);
      check("mrst_full", bus.full, 0);
      repeat (3) tick();
      rst = 1'b1;
      begin
         logic saw_low;
         logic saw_busy;
         saw_low  = 1'b0;
         saw_busy = 1'b0;
         for (int i = 0; i < 15 * DIV; i++) begin
            tick();
            if (txd !== 1'b1) saw_low = 1'b1;
            if (bus.busy !== 1'b0) saw_busy = 1'b1;
         end
         check("mrst_no_residual_txd", saw_low, 0);
         check("mrst_no_residual_busy", saw_busy, 0);
      end
      check("mrst_rx_len", rx_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
